// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rf_pkg
// Description : Shared constants for the register-file write arbiter and its
//               pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   localparam int DATA_W   = 32;   // register data width
   localparam int ADDR_W   = 5;    // register index width
   localparam int NUM_REGS = 32;   // architectural register count
   localparam int ZERO_REG = 0;    // hard-wired zero register, never written

   // Grant encoding, also used as the remembered "last granted" value
   localparam logic GNT_R0 = 1'b0; // ALU path
   localparam logic GNT_R1 = 1'b1; // mul/div path

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write scoreboard. Decode reserves a destination for a
//               long-latency op; the matching mul/div writeback releases it.
//               Tracks a busy bit per register and a saturating count of
//               outstanding reservations.
// Ports       : clk, rst_n       clock / async active-low reset
//               i_ena            block enable (0 holds all state)
//               i_rsv_valid/addr reservation request from decode
//               i_clr_valid/addr mul/div writeback accepted this cycle
//               o_busy_vec       per-register pending flag
//               o_pend_cnt       outstanding reservations (saturating)
//               o_rsv_dup        pulse: reservation hit a busy register
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
   parameter int ADDR_W = rf_pkg::ADDR_W,
   parameter int CNT_W  = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_ena,
   input  logic                     i_rsv_valid,
   input  logic [ADDR_W-1:0]        i_rsv_addr,
   input  logic                     i_clr_valid,
   input  logic [ADDR_W-1:0]        i_clr_addr,
   output logic [(1<<ADDR_W)-1:0]   o_busy_vec,
   output logic [CNT_W-1:0]         o_pend_cnt,
   output logic                     o_rsv_dup
);
   import rf_pkg::*;

   localparam int                c_NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] c_ZERO     = ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

   logic [c_NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_dup;

   logic                  w_set;
   logic                  w_clr;
   logic                  w_dup;
   logic [c_NUM_REGS-1:0] w_busy_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;

   always_comb begin
      w_set = i_ena & i_rsv_valid & (i_rsv_addr != c_ZERO);
      // A writeback to a register nobody reserved leaves the scoreboard alone,
      // which also keeps the counter from underflowing.
      w_clr = i_ena & i_clr_valid & (i_clr_addr != c_ZERO) & r_busy[i_clr_addr];
      w_dup = w_set & r_busy[i_rsv_addr];

      // Clear first, then set, so a same-register collision leaves it busy.
      w_busy_nxt = r_busy;
      if (w_clr) begin
         w_busy_nxt[i_clr_addr] = 1'b0;
      end
      if (w_set) begin
         w_busy_nxt[i_rsv_addr] = 1'b1;
      end

      // Simultaneous set and clear cancel; otherwise step with saturation.
      w_cnt_nxt = r_cnt;
      if (w_set && !w_clr && (r_cnt != c_CNT_MAX)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (w_clr && !w_set && (r_cnt != '0)) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end
   end

   // With i_ena low w_set/w_clr are 0, so busy and count hold and the
   // duplicate pulse drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_dup  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
         r_dup  <= w_dup;
      end
   end

   assign o_busy_vec = r_busy;
   assign o_pend_cnt = r_cnt;
   assign o_rsv_dup  = r_dup;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the single register-file write port between the ALU
//               writeback (r0) and the mul/div writeback (r1). Round-robin
//               grant, one registered write stage, and a pending-write
//               scoreboard used by decode to stall on outstanding results.
// Ports       : WA_clk, WA_rst_n   clock / async active-low reset
//               WA_ena             block enable (0 freezes state)
//               r0_* / r1_*        writeback requests, ready = accepted
//               rsv_valid/addr     destination reservation from decode
//               busy_vec, pend_cnt, rsv_dup   scoreboard status
//               rf_w, rf_rdc, rf_rd           register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W,
   parameter int CNT_W  = 6
) (
   input  logic                     WA_clk,
   input  logic                     WA_rst_n,
   input  logic                     WA_ena,
   input  logic                     r0_valid,
   input  logic [ADDR_W-1:0]        r0_addr,
   input  logic [DATA_W-1:0]        r0_data,
   output logic                     r0_ready,
   input  logic                     r1_valid,
   input  logic [ADDR_W-1:0]        r1_addr,
   input  logic [DATA_W-1:0]        r1_data,
   output logic                     r1_ready,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [(1<<ADDR_W)-1:0]   busy_vec,
   output logic [CNT_W-1:0]         pend_cnt,
   output logic                     rsv_dup,
   output logic                     rf_w,
   output logic [ADDR_W-1:0]        rf_rdc,
   output logic [DATA_W-1:0]        rf_rd
);
   import rf_pkg::*;

   localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(ZERO_REG);

   logic              r_last_grant;
   logic              r_rf_w;
   logic [ADDR_W-1:0] r_rf_rdc;
   logic [DATA_W-1:0] r_rf_rd;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_accept;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_data;

   // Round-robin: on a conflict the requester not granted last time wins.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (WA_ena) begin
         if (r0_valid && r1_valid) begin
            w_gnt0 = (r_last_grant == GNT_R1);
            w_gnt1 = (r_last_grant == GNT_R0);
         end else begin
            w_gnt0 = r0_valid;
            w_gnt1 = r1_valid;
         end
      end
      w_accept   = w_gnt0 | w_gnt1;
      w_acc_addr = w_gnt1 ? r1_addr : r0_addr;
      w_acc_data = w_gnt1 ? r1_data : r0_data;
   end

   assign r0_ready = w_gnt0;
   assign r1_ready = w_gnt1;

   // Write stage. Register-0 writes are accepted (the requester retires)
   // but produce no strobe; address/data hold between accepts.
   always_ff @(posedge WA_clk or negedge WA_rst_n) begin
      if (!WA_rst_n) begin
         r_rf_w       <= 1'b0;
         r_rf_rdc     <= '0;
         r_rf_rd      <= '0;
         r_last_grant <= GNT_R1;
      end else begin
         r_rf_w <= w_accept & (w_acc_addr != c_ZERO);
         if (w_accept) begin
            r_rf_rdc     <= w_acc_addr;
            r_rf_rd      <= w_acc_data;
            r_last_grant <= w_gnt1 ? GNT_R1 : GNT_R0;
         end
      end
   end

   assign rf_w   = r_rf_w;
   assign rf_rdc = r_rf_rdc;
   assign rf_rd  = r_rf_rd;

   // Only accepted mul/div writebacks release reservations.
   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_scoreboard (
      .clk         (WA_clk),
      .rst_n       (WA_rst_n),
      .i_ena       (WA_ena),
      .i_rsv_valid (rsv_valid),
      .i_rsv_addr  (rsv_addr),
      .i_clr_valid (w_gnt1),
      .i_clr_addr  (r1_addr),
      .o_busy_vec  (busy_vec),
      .o_pend_cnt  (pend_cnt),
      .o_rsv_dup   (rsv_dup)
   );

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter. A transaction-level
//               reference model predicts grants, scoreboard state and the
//               expected register-file writes; writes are queued and a
//               separate monitor pops them when the write port strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int CW   = 6;
   localparam int NR   = 1 << AW;
   localparam int PMAX = (1 << CW) - 1;

   logic          WA_clk = 1'b0;
   logic          WA_rst_n;
   logic          WA_ena;
   logic          r0_valid, r1_valid, rsv_valid;
   logic [AW-1:0] r0_addr, r1_addr, rsv_addr;
   logic [DW-1:0] r0_data, r1_data;
   logic          r0_ready, r1_ready;
   logic [NR-1:0] busy_vec;
   logic [CW-1:0] pend_cnt;
   logic          rsv_dup;
   logic          rf_w;
   logic [AW-1:0] rf_rdc;
   logic [DW-1:0] rf_rd;

   rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .WA_clk    (WA_clk),
      .WA_rst_n  (WA_rst_n),
      .WA_ena    (WA_ena),
      .r0_valid  (r0_valid),
      .r0_addr   (r0_addr),
      .r0_data   (r0_data),
      .r0_ready  (r0_ready),
      .r1_valid  (r1_valid),
      .r1_addr   (r1_addr),
      .r1_data   (r1_data),
      .r1_ready  (r1_ready),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .busy_vec  (busy_vec),
      .pend_cnt  (pend_cnt),
      .rsv_dup   (rsv_dup),
      .rf_w      (rf_w),
      .rf_rdc    (rf_rdc),
      .rf_rd     (rf_rd)
   );

   always #5 WA_clk = ~WA_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge WA_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            stamp;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   bit            m_busy[NR];
   int            m_pend;
   bit            m_dup;
   logic [AW-1:0] m_rdc;
   logic [DW-1:0] m_rd;
   int            m_last;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_pend = 0;
      m_dup  = 1'b0;
      m_rdc  = '0;
      m_rd   = '0;
      m_last = 1;
      exp_q.delete();
   endtask

   // Checks registered state against the model, predicts the grant for the
   // inputs presented now, then advances the model past the coming edge.
   always @(negedge WA_clk) begin : model
      logic [NR-1:0] bv;
      int            g;
      int            np;
      bit            set, clr, dup;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      if (!WA_rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < NR; i++) bv[i] = m_busy[i];
         check("busy_vec", 64'(busy_vec), 64'(bv));
         check("pend_cnt", 64'(pend_cnt), 64'(m_pend));
         check("rsv_dup",  64'(rsv_dup),  64'(m_dup));
         check("rf_rdc_hold", 64'(rf_rdc), 64'(m_rdc));
         check("rf_rd_hold",  64'(rf_rd),  64'(m_rd));

         g = -1;
         if (WA_ena) begin
            if (r0_valid && r1_valid) g = 1 - m_last;
            else if (r0_valid)        g = 0;
            else if (r1_valid)        g = 1;
         end
         check("r0_ready", 64'(r0_ready), 64'(g == 0));
         check("r1_ready", 64'(r1_ready), 64'(g == 1));

         set = 1'b0;
         clr = 1'b0;
         if (WA_ena) begin
            set = rsv_valid && (rsv_addr != 0);
            clr = (g == 1) && (r1_addr != 0) && m_busy[r1_addr];
         end
         dup = set && m_busy[rsv_addr];

         if (g >= 0) begin
            wa     = (g == 1) ? r1_addr : r0_addr;
            wd     = (g == 1) ? r1_data : r0_data;
            m_last = g;
            m_rdc  = wa;
            m_rd   = wd;
            if (wa != 0) exp_q.push_back('{cyc + 1, wa, wd});
         end
         if (clr) m_busy[r1_addr]  = 1'b0;
         if (set) m_busy[rsv_addr] = 1'b1;
         np     = m_pend + int'(set) - int'(clr);
         m_pend = (np < 0) ? 0 : ((np > PMAX) ? PMAX : np);
         m_dup  = dup;
      end
   end

   // ---------------- write-port monitor ----------------
   always @(negedge WA_clk) begin : monitor
      wr_t e;
      if (!WA_rst_n) begin
         exp_q.delete();
         check("rf_w_in_reset", 64'(rf_w), 64'(0));
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
         e = exp_q.pop_front();
         check("rf_w_strobe", 64'(rf_w),   64'(1));
         check("wr_addr",     64'(rf_rdc), 64'(e.a));
         check("wr_data",     64'(rf_rd),  64'(e.d));
      end else begin
         check("rf_w_idle", 64'(rf_w), 64'(0));
      end
   end

   // Requester-side handshake: a request retires once ready was seen.
   bit s_acc0, s_acc1;
   always @(negedge WA_clk) begin
      s_acc0 = r0_ready;
      s_acc1 = r1_ready;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge WA_clk);
      #1;
   endtask

   task automatic idle();
      r0_valid  = 1'b0;
      r1_valid  = 1'b0;
      rsv_valid = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      WA_rst_n = 1'b0;
      step();
      step();
      WA_rst_n = 1'b1;
   endtask

   initial begin
      WA_rst_n = 1'b1;
      WA_ena   = 1'b0;
      idle();
      r0_addr = '0; r0_data = '0;
      r1_addr = '0; r1_data = '0;
      rsv_addr = '0;
      #1 WA_rst_n = 1'b0;
      #2;
      check("rst_rf_w",     64'(rf_w),     64'(0));
      check("rst_rf_rdc",   64'(rf_rdc),   64'(0));
      check("rst_rf_rd",    64'(rf_rd),    64'(0));
      check("rst_busy_vec", 64'(busy_vec), 64'(0));
      check("rst_pend_cnt", 64'(pend_cnt), 64'(0));
      check("rst_rsv_dup",  64'(rsv_dup),  64'(0));
      step();
      step();
      WA_ena   = 1'b1;
      WA_rst_n = 1'b1;

      // single ALU write, latency one cycle
      r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'h1234;
      #1 check("tp1_r0_ready", 64'(r0_ready), 64'(1));
      step();
      r0_valid = 1'b0;
      check("tp1_rf_w",   64'(rf_w),   64'(1));
      check("tp1_rf_rdc", 64'(rf_rdc), 64'(5));
      check("tp1_rf_rd",  64'(rf_rd),  64'(32'h1234));
      step();
      check("tp1_rf_w_low", 64'(rf_w), 64'(0));

      // both requesting: r0 first after reset, then alternating
      apply_reset();
      r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hA;
      r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'hB;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("tp2_r0_ready%0d", k), 64'(r0_ready), 64'(k % 2 == 0));
         check($sformatf("tp2_r1_ready%0d", k), 64'(r1_ready), 64'(k % 2 == 1));
         step();
         check($sformatf("tp2_rf_rdc%0d", k), 64'(rf_rdc), 64'((k % 2 == 0) ? 3 : 7));
      end
      idle();
      step();

      // reservation then release by the mul/div path
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      step();
      rsv_valid = 1'b0;
      check("tp3_busy9_set", 64'(busy_vec[9]), 64'(1));
      check("tp3_pend_one",  64'(pend_cnt),    64'(1));
      step();
      step();
      r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'hCAFE_0009;
      step();
      r1_valid = 1'b0;
      check("tp3_busy9_clr", 64'(busy_vec[9]), 64'(0));
      check("tp3_pend_zero", 64'(pend_cnt),    64'(0));

      // register 0: accepted but never strobed, never reserved
      r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 32'hFFFF;
      #1 check("tp4_r0_ready", 64'(r0_ready), 64'(1));
      step();
      r0_valid = 1'b0;
      check("tp4_rf_w_zero", 64'(rf_w), 64'(0));
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      step();
      rsv_valid = 1'b0;
      check("tp4_busy_zero", 64'(busy_vec), 64'(0));
      check("tp4_pend_zero", 64'(pend_cnt), 64'(0));

      // same-cycle set and clear on one register: set wins, count unchanged
      rsv_valid = 1'b1; rsv_addr = 5'd4;
      step();
      r1_valid = 1'b1; r1_addr = 5'd4; r1_data = 32'h44;
      step();
      idle();
      check("tp5_busy4_kept", 64'(busy_vec[4]), 64'(1));
      check("tp5_pend_same",  64'(pend_cnt),    64'(1));

      // duplicate reservation
      apply_reset();
      rsv_valid = 1'b1; rsv_addr = 5'd4;
      step();
      step();
      rsv_valid = 1'b0;
      check("tp5_dup_pulse", 64'(rsv_dup),  64'(1));
      check("tp5_pend_two",  64'(pend_cnt), 64'(2));
      step();
      check("tp5_dup_drop",  64'(rsv_dup),  64'(0));

      // asynchronous reset while a write is staged
      apply_reset();
      rsv_valid = 1'b1; rsv_addr = 5'd12;
      step();
      rsv_valid = 1'b0;
      r0_valid = 1'b1; r0_addr = 5'd12; r0_data = 32'h1212;
      step();
      r0_valid = 1'b0;
      check("tp6_staged_w",  64'(rf_w),         64'(1));
      check("tp6_busy12",    64'(busy_vec[12]), 64'(1));
      #1 WA_rst_n = 1'b0;
      #1;
      check("tp6_arst_rf_w", 64'(rf_w),     64'(0));
      check("tp6_arst_busy", 64'(busy_vec), 64'(0));
      check("tp6_arst_pend", 64'(pend_cnt), 64'(0));
      step();
      WA_rst_n = 1'b1;

      // enable low: no grants, reservations ignored, state held
      WA_ena = 1'b0;
      r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h11;
      r1_valid = 1'b1; r1_addr = 5'd2; r1_data = 32'h22;
      rsv_valid = 1'b1; rsv_addr = 5'd6;
      #1;
      check("tp6_ena0_r0_ready", 64'(r0_ready), 64'(0));
      check("tp6_ena0_r1_ready", 64'(r1_ready), 64'(0));
      step();
      step();
      check("tp6_ena0_busy", 64'(busy_vec), 64'(0));
      check("tp6_ena0_pend", 64'(pend_cnt), 64'(0));
      check("tp6_ena0_rf_w", 64'(rf_w),     64'(0));
      WA_ena = 1'b1;
      step();
      idle();
      step();
      step();

      // counter saturation
      apply_reset();
      rsv_valid = 1'b1;
      for (int k = 0; k < PMAX + 8; k++) begin
         rsv_addr = AW'($urandom_range(1, NR - 1));
         step();
      end
      rsv_valid = 1'b0;
      check("sat_pend_max", 64'(pend_cnt), 64'(PMAX));
      step();

      // randomized traffic checked by the model and monitor
      apply_reset();
      for (int c = 0; c < 2000; c++) begin
         if (s_acc0 || !r0_valid) begin
            r0_valid = ($urandom_range(0, 9) < 6);
            r0_addr  = AW'($urandom_range(0, NR - 1));
            r0_data  = $urandom;
         end
         if (s_acc1 || !r1_valid) begin
            r1_valid = ($urandom_range(0, 9) < 5);
            r1_addr  = AW'($urandom_range(0, 7));
            r1_data  = $urandom;
         end
         rsv_valid = ($urandom_range(0, 9) < 3);
         rsv_addr  = AW'($urandom_range(0, 7));
         WA_ena    = ($urandom_range(0, 9) != 0);
         step();
      end
      idle();
      WA_ena = 1'b1;
      step();
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rf_write_arbiter
`default_nettype wire
